// File: rtl/maxmin_pkg.sv
// Shared types and constants for the max/min engine and its request scheduler.
package maxmin_pkg;

  localparam int unsigned BURST_LEN_DEF = 15;
  localparam int unsigned DATA_W_DEF    = 8;

  // Reset values of the shared engine's result registers.
  localparam logic [DATA_W_DEF-1:0] ENG_MAX_RST = 8'h00;
  localparam logic [DATA_W_DEF-1:0] ENG_MIN_RST = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_WAIT,
    S_RESULT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    gnt_id
);

  int unsigned idx;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/maxmin_scheduler.sv
// Shares one max/min engine between NUM_REQ requesters: buffers a granted burst,
// replays it gap-free to the engine and returns the tagged result.
module maxmin_scheduler
  import maxmin_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned RESP_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_num,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        eng_in_valid,
  output logic [DATA_W-1:0]           eng_in_num,
  input  logic                        eng_out_valid,
  input  logic [DATA_W-1:0]           eng_out_max,
  input  logic [DATA_W-1:0]           eng_out_min,
  output logic                        res_valid,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic [DATA_W-1:0]           res_max,
  output logic [DATA_W-1:0]           res_min,
  output logic                        err,
  output logic                        busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned TO_W  = $clog2(RESP_TIMEOUT + 1);

  sched_state_t         state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]    sbuf_q [BURST_LEN];

  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 eng_in_valid_q, eng_in_valid_d;
  logic [DATA_W-1:0]    eng_in_num_q, eng_in_num_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [DATA_W-1:0]    res_max_q, res_max_d;
  logic [DATA_W-1:0]    res_min_q, res_min_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 arb_found;
  logic [ID_W-1:0]      arb_gnt;
  logic                 fill_hs;
  logic                 buf_we;
  logic [DATA_W-1:0]    fill_num;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .found     (arb_found),
    .gnt_id    (arb_gnt)
  );

  assign fill_num = req_num[gnt_id_q*DATA_W +: DATA_W];
  assign fill_hs  = (state_q == S_FILL) && req_valid[gnt_id_q] && req_ready_q[gnt_id_q];

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_id_d       = gnt_id_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    to_cnt_d       = to_cnt_q;
    req_ready_d    = '0;
    eng_in_valid_d = 1'b0;
    eng_in_num_d   = eng_in_num_q;
    res_valid_d    = 1'b0;
    res_id_d       = res_id_q;
    res_max_d      = res_max_q;
    res_min_d      = res_min_q;
    err_d          = err_q;
    buf_we         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_id_d    = arb_gnt;
          rr_ptr_d    = ID_W'((32'(arb_gnt) + 1) % NUM_REQ);
          wr_cnt_d    = '0;
          req_ready_d = NUM_REQ'(1) << arb_gnt;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        req_ready_d = req_ready_q;
        if (fill_hs) begin
          buf_we = 1'b1;
          if (wr_cnt_q == CNT_W'(BURST_LEN - 1)) begin
            // First replay word is issued on the closing handshake so DRAIN starts at f+1.
            req_ready_d    = '0;
            eng_in_valid_d = 1'b1;
            eng_in_num_d   = (wr_cnt_q == '0) ? fill_num : sbuf_q[0];
            rd_cnt_d       = CNT_W'(1);
            wr_cnt_d       = CNT_W'(BURST_LEN);
            state_d        = S_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (rd_cnt_q < CNT_W'(BURST_LEN)) begin
          eng_in_valid_d = 1'b1;
          eng_in_num_d   = sbuf_q[rd_cnt_q];
          rd_cnt_d       = rd_cnt_q + 1'b1;
        end else begin
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_out_valid) begin
          res_valid_d = 1'b1;
          res_id_d    = gnt_id_q;
          res_max_d   = eng_out_max;
          res_min_d   = eng_out_min;
          state_d     = S_RESULT;
        end else if (to_cnt_q == TO_W'(RESP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      gnt_id_q       <= '0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      to_cnt_q       <= '0;
      req_ready_q    <= '0;
      eng_in_valid_q <= 1'b0;
      eng_in_num_q   <= '0;
      res_valid_q    <= 1'b0;
      res_id_q       <= '0;
      // Engine reset values, widened to DATA_W by bit replication.
      res_max_q      <= {DATA_W{ENG_MAX_RST[0]}};
      res_min_q      <= {DATA_W{ENG_MIN_RST[0]}};
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_id_q       <= gnt_id_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      to_cnt_q       <= to_cnt_d;
      req_ready_q    <= req_ready_d;
      eng_in_valid_q <= eng_in_valid_d;
      eng_in_num_q   <= eng_in_num_d;
      res_valid_q    <= res_valid_d;
      res_id_q       <= res_id_d;
      res_max_q      <= res_max_d;
      res_min_q      <= res_min_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) sbuf_q[wr_cnt_q] <= fill_num;
  end

  assign req_ready    = req_ready_q;
  assign eng_in_valid = eng_in_valid_q;
  assign eng_in_num   = eng_in_num_q;
  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_max      = res_max_q;
  assign res_min      = res_min_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_maxmin_scheduler.sv
// Directed/randomized bench for maxmin_scheduler with a behavioural engine and result model.
module tb_maxmin_scheduler;

  localparam int NR = 4;
  localparam int BL = 15;
  localparam int DW = 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_num;
  logic [NR-1:0]     req_ready;
  logic              eng_in_valid;
  logic [DW-1:0]     eng_in_num;
  logic              eng_out_valid;
  logic [DW-1:0]     eng_out_max;
  logic [DW-1:0]     eng_out_min;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [DW-1:0]     res_max;
  logic [DW-1:0]     res_min;
  logic              err;
  logic              busy;

  always #5 clk = ~clk;

  maxmin_scheduler #(
    .NUM_REQ      (NR),
    .BURST_LEN    (BL),
    .DATA_W       (DW),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_num       (req_num),
    .req_ready     (req_ready),
    .eng_in_valid  (eng_in_valid),
    .eng_in_num    (eng_in_num),
    .eng_out_valid (eng_out_valid),
    .eng_out_max   (eng_out_max),
    .eng_out_min   (eng_out_min),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_max       (res_max),
    .res_min       (res_min),
    .err           (err),
    .busy          (busy)
  );

  // Engine model: result one cycle after the BL-th consecutive sample; any gap restarts it.
  bit          eng_mute;
  int          ecnt;
  logic [DW-1:0] emax, emin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt <= 0; eng_out_valid <= 1'b0; eng_out_max <= '0; eng_out_min <= '1;
      emax <= '0; emin <= '1;
    end else if (eng_in_valid) begin
      emax <= (ecnt == 0 || eng_in_num > emax) ? eng_in_num : emax;
      emin <= (ecnt == 0 || eng_in_num < emin) ? eng_in_num : emin;
      if (ecnt == BL - 1) begin
        eng_out_valid <= !eng_mute;
        eng_out_max   <= (eng_in_num > emax) ? eng_in_num : emax;
        eng_out_min   <= (eng_in_num < emin) ? eng_in_num : emin;
        ecnt          <= 0;
      end else begin
        ecnt          <= ecnt + 1;
        eng_out_valid <= 1'b0;
      end
    end else begin
      ecnt <= 0; eng_out_valid <= 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int id; int mx; int mn; } res_t;

  logic [DW-1:0] hist [NR][$];
  int  sent [NR];
  int  hold [NR];
  int  gap_after [NR];
  int  gap_len [NR];
  int  drained [NR];
  int  done_q [$];
  res_t res_exp [$];
  int  res_log [$];
  int  run_len, owner, drain_base, drain_first, drain_last, res_cyc, last_hs, cyc, err_cyc;
  bit  err_seen;

  function automatic res_t burst_ref(int id, int base);
    res_t r;
    r.id = id; r.mx = 0; r.mn = 255;
    for (int k = 0; k < BL; k++) begin
      if (int'(hist[id][base+k]) > r.mx) r.mx = int'(hist[id][base+k]);
      if (int'(hist[id][base+k]) < r.mn) r.mn = int'(hist[id][base+k]);
    end
    return r;
  endfunction

  function automatic bit pending();
    bit p = busy || (run_len > 0) || (res_exp.size() != 0);
    for (int i = 0; i < NR; i++) if (sent[i] < hist[i].size()) p = 1'b1;
    return p;
  endfunction

  task automatic monitor();
    res_t e;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (eng_in_valid) begin
      if (run_len == 0) begin
        if (done_q.size() == 0) begin
          chk("drain_owner", 32'(done_q.size()), 32'd1);
          owner = 0;
        end else owner = done_q.pop_front();
        drain_base = drained[owner] * BL;
        drained[owner]++;
        drain_first = cyc;
      end
      if (run_len < BL) chk("drain_data", 32'(eng_in_num), 32'(hist[owner][drain_base+run_len]));
      else              chk("drain_len_over", 32'(run_len), 32'(BL - 1));
      run_len++;
      drain_last = cyc;
    end else if (run_len > 0) begin
      chk("drain_len", 32'(run_len), 32'(BL));
      if (!eng_mute) res_exp.push_back(burst_ref(owner, drain_base));
      run_len = 0;
    end
    if (res_valid) begin
      res_cyc = cyc;
      if (res_exp.size() == 0) chk("res_unexpected", 32'(res_exp.size()), 32'd1);
      else begin
        e = res_exp.pop_front();
        chk("res_id",  32'(res_id),  32'(e.id));
        chk("res_max", 32'(res_max), 32'(e.mx));
        chk("res_min", 32'(res_min), 32'(e.mn));
        res_log.push_back(int'(res_id));
      end
    end
    if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
  endtask

  // One clock: observe at the falling edge, drive requesters, then advance.
  task automatic tick();
    logic [NR-1:0]    rv, fire;
    logic [NR*DW-1:0] rn;
    monitor();
    rv = '0; fire = '0; rn = '0;
    for (int i = 0; i < NR; i++) begin
      if (sent[i] < hist[i].size() && hold[i] == 0) begin
        rv[i] = 1'b1;
        rn[i*DW +: DW] = hist[i][sent[i]];
        fire[i] = req_ready[i];
      end else if (hold[i] > 0) hold[i]--;
    end
    req_valid = rv;
    req_num   = rn;
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        last_hs = cyc;
        sent[i]++;
        if (sent[i] % BL == 0) done_q.push_back(i);
        if (sent[i] == gap_after[i]) hold[i] = gap_len[i];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while (n < budget && pending()) begin tick(); n++; end
    chk(tag, 32'(pending()), 32'd0);
    tick(); tick();
  endtask

  task automatic load_rand(input int id);
    for (int k = 0; k < BL; k++) hist[id].push_back(DW'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] single_v [BL] = '{3, 9, 17, 42, 77, 100, 128, 160, 200, 199, 250, 5, 64, 33, 1};
    int n, nres;

    rst = 1'b1; req_valid = '0; req_num = '0; eng_mute = 1'b0;
    run_len = 0; cyc = 0; err_seen = 1'b0; last_hs = 0;
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0; hold[i] = 0; gap_after[i] = -1; gap_len[i] = 0; drained[i] = 0;
    end
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_eng_valid", 32'(eng_in_valid), 32'd0);
    chk("rst_eng_num",   32'(eng_in_num), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id",    32'(res_id), 32'd0);
    chk("rst_res_max",   32'(res_max), 32'd0);
    chk("rst_res_min",   32'(res_min), 32'hFF);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Round-robin with every requester holding req_valid.
    for (int i = 0; i < NR; i++) load_rand(i);
    load_rand(0);
    run_until_done(800, "rr_done");
    chk("rr_count", 32'(res_log.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < res_log.size()) chk("rr_order", 32'(res_log[k]), 32'(rr_exp[k]));

    // Single requester, fixed data, latency checks.
    res_log.delete();
    for (int k = 0; k < BL; k++) hist[2].push_back(single_v[k]);
    tick();
    chk("grant_latency", 32'(req_ready), 32'b0100);
    run_until_done(200, "single_done");
    chk("single_count",    32'(res_log.size()), 32'd1);
    chk("single_max",      32'(res_max), 32'd250);
    chk("single_min",      32'(res_min), 32'd1);
    chk("drain_start_lat", 32'(drain_first), 32'(last_hs + 1));
    chk("drain_end_lat",   32'(drain_last), 32'(last_hs + BL));
    chk("result_lat",      32'(res_cyc), 32'(last_hs + BL + 2));

    // Requester 0 pauses 3 cycles after sample 7.
    gap_after[0] = sent[0] + 7; gap_len[0] = 3;
    load_rand(0);
    run_until_done(200, "gap_done");
    chk("gap_count", 32'(res_log.size()), 32'd2);

    // All-equal burst.
    for (int k = 0; k < BL; k++) hist[3].push_back(8'h80);
    run_until_done(200, "equal_done");
    chk("equal_max", 32'(res_max), 32'h80);
    chk("equal_min", 32'(res_min), 32'h80);

    // Engine never answers: err after timeout, then the next grant still completes.
    nres = res_log.size();
    eng_mute = 1'b1; err_seen = 1'b0;
    load_rand(1);
    run_until_done(200, "timeout_done");
    chk("timeout_err",     32'(err), 32'd1);
    chk("timeout_err_lat", 32'(err_cyc), 32'(drain_last + 5));
    chk("timeout_no_res",  32'(res_log.size()), 32'(nres));
    eng_mute = 1'b0;
    load_rand(2);
    run_until_done(200, "after_to_done");
    chk("after_to_res",  32'(res_log.size()), 32'(nres + 1));
    chk("err_sticky",    32'(err), 32'd1);

    // Reset asserted while the 7th replay sample is on the bus.
    load_rand(3);
    n = 0;
    while (run_len < 6 && n < 200) begin tick(); n++; end
    chk("reach_sample6", 32'(run_len), 32'd6);
    rst = 1'b1; req_valid = '0;
    #1;
    chk("midrst_eng_valid", 32'(eng_in_valid), 32'd0);
    chk("midrst_busy",      32'(busy), 32'd0);
    chk("midrst_ready",     32'(req_ready), 32'd0);
    chk("midrst_err",       32'(err), 32'd0);
    chk("midrst_res_min",   32'(res_min), 32'hFF);
    run_len = 0; done_q.delete(); res_exp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nres = res_log.size();
    load_rand(1);
    run_until_done(200, "post_rst_done");
    chk("post_rst_res", 32'(res_log.size()), 32'(nres + 1));
    if (res_log.size() > 0) chk("post_rst_id", 32'(res_log[res_log.size()-1]), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
